fetch_unit: RTL and testbench

//  Parametrised instruction-fetch stage. Owns the fetch PC and issues in-order requests
//  to instruction memory over a req/gnt + rvalid interface. Buffers returned instructions
//  in a FQ_DEPTH-entry fetch queue and presents them to decode with valid/ready.
//  A branch redirect flushes the queue and discards responses already in flight.

---
 rtl/fetch_unit.sv | 135 +++++++++++++
 tb/tb_fetch_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests over req/gnt + rvalid,
// buffers responses in a small fetch queue and hands them to decode; redirects flush and discard.
module fetch_unit #(
   parameter int              PC_W     = 16,
   parameter int              INSTR_W  = 9,
   parameter int              FQ_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          redirect,
   input  logic [PC_W-1:0]               redirect_pc,
   output logic                          imem_req,
   output logic [PC_W-1:0]               imem_addr,
   input  logic                          imem_gnt,
   input  logic                          imem_rvalid,
   input  logic [INSTR_W-1:0]            imem_rdata,
   output logic                          dec_valid,
   output logic [INSTR_W-1:0]            dec_instr,
   output logic [PC_W-1:0]               dec_pc,
   input  logic                          dec_ready,
   output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count
);

   localparam int              CW        = $clog2(FQ_DEPTH + 1);
   localparam int              AW        = $clog2(FQ_DEPTH);
   localparam logic [CW-1:0]   DEPTH_C   = CW'(FQ_DEPTH);
   localparam logic [AW-1:0]   LAST_SLOT = AW'(FQ_DEPTH - 1);

   logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0]    resp_pc_q, resp_pc_d;
   logic [CW-1:0]      count_q, count_d;
   logic [CW-1:0]      outstanding_q, outstanding_d;
   logic [CW-1:0]      discard_q, discard_d;
   logic [AW-1:0]      head_q, head_d;
   logic [AW-1:0]      tail_q, tail_d;
   logic               run_q;
   logic [PC_W-1:0]    fq_pc_q    [FQ_DEPTH];
   logic [INSTR_W-1:0] fq_instr_q [FQ_DEPTH];

   logic has_room;
   logic issue;
   logic rsp;
   logic push;
   logic pop;

   function automatic logic [AW-1:0] next_slot(input logic [AW-1:0] p);
      return (p == LAST_SLOT) ? '0 : p + AW'(1);
   endfunction

   // Queued plus in-flight entries share one budget, so every accepted response has a slot.
   assign has_room  = ({1'b0, count_q} + {1'b0, outstanding_q}) < {1'b0, DEPTH_C};
   assign imem_req  = run_q & ~redirect & has_room;
   assign imem_addr = fetch_pc_q;
   assign issue     = imem_req & imem_gnt;

   assign rsp  = imem_rvalid & (outstanding_q != '0);
   assign push = rsp & ~redirect & (discard_q == '0);

   assign dec_valid = (count_q != '0) & ~redirect;
   assign dec_instr = fq_instr_q[head_q];
   assign dec_pc    = fq_pc_q[head_q];
   assign pop       = dec_valid & dec_ready;
   assign fq_count  = count_q;

   // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      count_d       = count_q;
      discard_d     = discard_q;
      head_d        = head_q;
      tail_d        = tail_q;
      outstanding_d = outstanding_q + CW'(issue) - CW'(rsp);

      if (redirect) begin
         fetch_pc_d = redirect_pc;
         resp_pc_d  = redirect_pc;
         count_d    = '0;
         head_d     = '0;
         tail_d     = '0;
         discard_d  = outstanding_q - CW'(rsp);
      end else begin
         if (issue) fetch_pc_d = fetch_pc_q + PC_W'(1);
         if (push) begin
            resp_pc_d = resp_pc_q + PC_W'(1);
            tail_d    = next_slot(tail_q);
         end
         if (pop) head_d = next_slot(head_q);
         if (rsp && (discard_q != '0)) discard_d = discard_q - CW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         count_q       <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         run_q         <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         run_q         <= 1'b1;
      end
   end

   // NOTE: queue storage is not reset; count_q alone decides which slots hold valid data.
   always_ff @(posedge clk) begin
      if (push) begin
         fq_pc_q[tail_q]    <= resp_pc_q;
         fq_instr_q[tail_q] <= imem_rdata;
      end
   end

   rvalid_needs_request: assert property (@(posedge clk) disable iff (!reset)
      imem_rvalid |-> (outstanding_q != '0));
   queue_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      push |-> ((count_q != DEPTH_C) || pop));
   queue_no_underflow: assert property (@(posedge clk) disable iff (!reset)
      pop |-> (count_q != '0));
   counters_bounded: assert property (@(posedge clk) disable iff (!reset)
      (discard_q <= outstanding_q) && (outstanding_q <= DEPTH_C));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a cycle-stepped imem model with in-order responses,
// an expected-decode queue filled on grants and drained on decode pops.
module tb_fetch_unit;
   localparam int PC_W     = 16;
   localparam int INSTR_W  = 9;
   localparam int FQ_DEPTH = 4;
   localparam int CW       = $clog2(FQ_DEPTH + 1);

   typedef struct { logic [PC_W-1:0] addr; int due; } req_t;
   typedef struct { logic [PC_W-1:0] pc; logic [INSTR_W-1:0] instr; } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic               redirect = 1'b0;
   logic [PC_W-1:0]    redirect_pc = '0;
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_gnt = 1'b0;
   logic               imem_rvalid = 1'b0;
   logic [INSTR_W-1:0] imem_rdata = '0;
   logic               dec_valid;
   logic [INSTR_W-1:0] dec_instr;
   logic [PC_W-1:0]    dec_pc;
   logic               dec_ready = 1'b0;
   logic [CW-1:0]      fq_count;

   logic               w_redirect = 1'b0;
   logic [PC_W-1:0]    w_redirect_pc = '0;
   logic               w_req;
   logic [PC_W-1:0]    w_addr;
   logic               w_gnt = 1'b0;
   logic               w_rvalid = 1'b0;
   logic [INSTR_W-1:0] w_rdata = '0;
   logic               w_dec_valid;
   logic [INSTR_W-1:0] w_dec_instr;
   logic [PC_W-1:0]    w_dec_pc;
   logic               w_ready = 1'b0;
   logic [CW-1:0]      w_fq_count;

   fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(16'h0000)) dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
      .dec_ready(dec_ready), .fq_count(fq_count));

   fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .FQ_DEPTH(FQ_DEPTH), .RESET_PC(16'hFFFE)) u_wrap (
      .clk(clk), .reset(reset), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
      .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
      .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
      .dec_valid(w_dec_valid), .dec_instr(w_dec_instr), .dec_pc(w_dec_pc),
      .dec_ready(w_ready), .fq_count(w_fq_count));

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int gnt_prob = 100;
   int lat = 1;
   int jitter = 0;
   int grants = 0;
   int stale_cnt = 0;
   int model_count = 0;
   bit last_gnt = 1'b0;
   logic [PC_W-1:0] last_gnt_addr = '0;
   logic [PC_W-1:0] exp_fetch_pc = '0;
   req_t pending[$];
   exp_t exp_q[$];
   logic [PC_W-1:0] pop_log[$];

   function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
      logic [PC_W-1:0] t;
      t = a ^ (a >> 7) ^ 16'h0135;
      return t[INSTR_W-1:0];
   endfunction

   task automatic clear_model();
      pending.delete();
      exp_q.delete();
      pop_log.delete();
      stale_cnt    = 0;
      model_count  = 0;
      grants       = 0;
      last_gnt     = 1'b0;
      exp_fetch_pc = 16'h0000;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; dec_ready = 1'b0;
      w_gnt = 1'b0; w_rvalid = 1'b0; w_ready = 1'b0;
      clear_model();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // One clock cycle: drive inputs and the imem response, then check outputs against the model.
   task automatic step(input bit rdr, input logic [PC_W-1:0] rpc, input bit rdy);
      req_t r;
      exp_t e;
      bit   rsp_now;
      logic exp_valid;
      @(negedge clk);
      cyc++;
      redirect    = rdr;
      redirect_pc = rpc;
      dec_ready   = rdy;
      imem_gnt    = (int'($urandom_range(99)) < gnt_prob);
      rsp_now     = 1'b0;
      if (pending.size() > 0 && pending[0].due <= cyc) begin
         r = pending.pop_front();
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(r.addr);
         rsp_now     = 1'b1;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = INSTR_W'($urandom);
      end
      #1;
      exp_valid = (model_count != 0) && !rdr;
      total++;
      if (fq_count !== CW'(model_count)) begin
         bad++;
         $display("FAIL fq_count @%0d: got %0d want %0d", cyc, fq_count, model_count);
      end
      total++;
      if (dec_valid !== exp_valid) begin
         bad++;
         $display("FAIL dec_valid @%0d: got %b want %b", cyc, dec_valid, exp_valid);
      end
      if (dec_valid === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL dec_head @%0d: got pc=%0h want empty queue", cyc, dec_pc);
         end else if (dec_pc !== exp_q[0].pc || dec_instr !== exp_q[0].instr) begin
            bad++;
            $display("FAIL dec_head @%0d: got pc=%0h instr=%0h want pc=%0h instr=%0h",
                     cyc, dec_pc, dec_instr, exp_q[0].pc, exp_q[0].instr);
         end
         if (rdy && exp_q.size() > 0) begin
            pop_log.push_back(dec_pc);
            void'(exp_q.pop_front());
         end
      end
      last_gnt = 1'b0;
      if (imem_req === 1'b1 && imem_gnt === 1'b1) begin
         total++;
         if (imem_addr !== exp_fetch_pc) begin
            bad++;
            $display("FAIL imem_addr @%0d: got %0h want %0h", cyc, imem_addr, exp_fetch_pc);
         end
         last_gnt      = 1'b1;
         last_gnt_addr = imem_addr;
         grants++;
         e.pc    = exp_fetch_pc;
         e.instr = mem_word(exp_fetch_pc);
         exp_q.push_back(e);
         r.addr = imem_addr;
         r.due  = cyc + lat + int'($urandom_range(jitter));
         pending.push_back(r);
         exp_fetch_pc = exp_fetch_pc + PC_W'(1);
      end
      if (rdr) begin
         total++;
         if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL req_on_redirect @%0d: got %b want 0", cyc, imem_req);
         end
         exp_q.delete();
         stale_cnt    = pending.size();
         model_count  = 0;
         exp_fetch_pc = rpc;
      end else begin
         if (exp_valid && rdy) model_count--;
         if (rsp_now) begin
            if (stale_cnt > 0) stale_cnt--;
            else model_count++;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      clear_model();
      repeat (3) @(negedge clk);
      #1;
      total += 5;
      if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
      if (dec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", dec_valid); end
      if (fq_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", fq_count); end
      if (w_addr !== 16'hFFFE) begin bad++; $display("FAIL reset_pc: got %0h want fffe", w_addr); end
      if (w_fq_count !== '0) begin bad++; $display("FAIL reset_wcount: got %0d want 0", w_fq_count); end
      @(negedge clk);
      reset = 1'b1;
      gnt_prob = 0; lat = 1; jitter = 0;
      step(1'b0, '0, 1'b0);
      total += 2;
      if (imem_req !== 1'b1) begin bad++; $display("FAIL release_req: got %b want 1", imem_req); end
      if (imem_addr !== 16'h0000) begin bad++; $display("FAIL release_addr: got %0h want 0", imem_addr); end
      gnt_prob = 100;
      repeat (6) step(1'b0, '0, 1'b1);
      total++;
      if (dec_valid !== 1'b1) begin bad++; $display("FAIL stream_before_reset: got %b want 1", dec_valid); end
      #2;
      reset = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
      #1;
      total += 3;
      if (imem_req !== 1'b0) begin bad++; $display("FAIL async_req: got %b want 0", imem_req); end
      if (dec_valid !== 1'b0) begin bad++; $display("FAIL async_valid: got %b want 0", dec_valid); end
      if (fq_count !== '0) begin bad++; $display("FAIL async_count: got %0d want 0", fq_count); end
      clear_model();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_stream();
      apply_reset();
      gnt_prob = 100; lat = 1; jitter = 0;
      repeat (20) step(1'b0, '0, 1'b1);
      total++;
      if (pop_log.size() != 18) begin
         bad++; $display("FAIL stream_rate: got %0d pops want 18", pop_log.size());
      end
      for (int i = 0; i < 8 && i < pop_log.size(); i++) begin
         total++;
         if (pop_log[i] !== PC_W'(i)) begin
            bad++; $display("FAIL stream_pc[%0d]: got %0h want %0h", i, pop_log[i], i);
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      apply_reset();
      gnt_prob = 100; lat = 1; jitter = 0;
      repeat (10) step(1'b0, '0, 1'b0);
      total += 3;
      if (grants != 4) begin bad++; $display("FAIL bp_grants: got %0d want 4", grants); end
      if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req: got %b want 0", imem_req); end
      if (fq_count !== CW'(4)) begin bad++; $display("FAIL bp_count: got %0d want 4", fq_count); end
      step(1'b0, '0, 1'b1);
      for (n = 0; n < 10 && !last_gnt; n++) step(1'b0, '0, 1'b1);
      total++;
      if (!last_gnt || last_gnt_addr !== 16'h0004) begin
         bad++; $display("FAIL bp_resume: got granted=%b addr=%0h want addr 4", last_gnt, last_gnt_addr);
      end
      repeat (6) step(1'b0, '0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (i >= pop_log.size() || pop_log[i] !== PC_W'(i)) begin
            bad++; $display("FAIL bp_pop[%0d]: got %0d pops want pc %0h", i, pop_log.size(), i);
         end
      end
   endtask

   task automatic test_redirect();
      apply_reset();
      gnt_prob = 100; lat = 3; jitter = 0;
      repeat (2) step(1'b0, '0, 1'b1);
      step(1'b1, 16'h0040, 1'b1);
      repeat (15) step(1'b0, '0, 1'b1);
      total += 2;
      if (pop_log.size() < 2 || pop_log[0] !== 16'h0040 || pop_log[1] !== 16'h0041) begin
         bad++; $display("FAIL redirect_first: got %0d pops first=%0h want 40,41",
                         pop_log.size(), (pop_log.size() > 0) ? pop_log[0] : 16'hxxxx);
      end
      if (grants < 2) begin bad++; $display("FAIL redirect_issue: got %0d grants want >=2", grants); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      gnt_prob = 100; lat = 2; jitter = 0;
      repeat (3) step(1'b0, '0, 1'b0);
      step(1'b1, 16'h0080, 1'b1);
      step(1'b1, 16'h0090, 1'b1);
      repeat (12) step(1'b0, '0, 1'b1);
      total++;
      if (pop_log.size() < 2 || pop_log[0] !== 16'h0090 || pop_log[1] !== 16'h0091) begin
         bad++; $display("FAIL b2b_redirect: got %0d pops first=%0h want 90,91",
                         pop_log.size(), (pop_log.size() > 0) ? pop_log[0] : 16'hxxxx);
      end
   endtask

   task automatic test_wrap();
      bit pv;
      logic [PC_W-1:0] pa;
      logic [PC_W-1:0] addr_log[$];
      logic [PC_W-1:0] dec_log[$];
      logic [PC_W-1:0] want[3];
      want[0] = 16'hFFFE; want[1] = 16'hFFFF; want[2] = 16'h0000;
      apply_reset();
      pv = 1'b0;
      pa = '0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         w_rvalid = pv;
         w_rdata  = mem_word(pa);
         w_gnt    = 1'b1;
         w_ready  = 1'b1;
         #1;
         if (w_dec_valid === 1'b1) begin
            dec_log.push_back(w_dec_pc);
            total++;
            if (w_dec_instr !== mem_word(w_dec_pc)) begin
               bad++; $display("FAIL wrap_instr: got %0h want %0h", w_dec_instr, mem_word(w_dec_pc));
            end
         end
         pv = (w_req === 1'b1);
         if (pv) begin
            addr_log.push_back(w_addr);
            pa = w_addr;
         end
      end
      @(negedge clk);
      w_gnt = 1'b0; w_rvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         total += 2;
         if (i >= addr_log.size() || addr_log[i] !== want[i]) begin
            bad++; $display("FAIL wrap_addr[%0d]: got %0d issued want %0h", i, addr_log.size(), want[i]);
         end
         if (i >= dec_log.size() || dec_log[i] !== want[i]) begin
            bad++; $display("FAIL wrap_dec[%0d]: got %0d decoded want %0h", i, dec_log.size(), want[i]);
         end
      end
   endtask

   task automatic test_random();
      apply_reset();
      gnt_prob = 60; lat = 1; jitter = 3;
      for (int i = 0; i < 10000; i++) begin
         step(int'($urandom_range(99)) < 4, PC_W'($urandom), bit'($urandom_range(1)));
      end
      gnt_prob = 0;
      repeat (30) step(1'b0, '0, 1'b1);
      total += 3;
      if (exp_q.size() != 0) begin bad++; $display("FAIL rand_lost: got %0d undelivered want 0", exp_q.size()); end
      if (pending.size() != 0) begin bad++; $display("FAIL rand_pending: got %0d want 0", pending.size()); end
      if (fq_count !== '0) begin bad++; $display("FAIL rand_drain: got %0d want 0", fq_count); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_back_to_back();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
